seh_rr_arbiter: RTL and testbench
=================================

# seh_rr_arbiter

Round-robin arbiter that shares a single downstream resource (for example an SPI flash port, a shared SRAM bank, or an I2C master) between up to N requesters on the iCE40UP fabric. The request vector is OR-reduced to detect any pending request, and exactly one requester is granted at a time. A grant is held until its owner releases it. This block sits between the requesting engines and the shared resource's mux-select logic; `gnt_id` drives that mux directly.

## Interface
- `N`, default 4: number of requesters; legal range 2..8.
- `TIMEOUT`, default 255: maximum cycles a grant may be held; used only when `SEH_RR_ARB_TIMEOUT_EN` is defined; legal range 1..65535.
- `clk` input 1: system clock, rising-edge.
- `resetn` input 1: synchronous, active-low reset.
- `req` input N: level requests; bit i held high by requester i for as long as it needs the resource.
- `gnt` output N: registered one-hot grant; all-zero when idle.
- `gnt_valid` output 1: registered; equals OR-reduction of `gnt`.
- `gnt_id` output clog2(N): registered index of the current owner; holds its last value when idle.
- `any_req` output 1: registered OR-reduction of `req`, delayed one cycle.
- `timeout` output 1: one-cycle pulse on forced release; constant 0 when the macro is absent.

## Operation
- There are two states:
  - IDLE: `gnt` is 0.
  - GRANT: `gnt` is one-hot.
- Priority pointer `last` holds the index of the most recent owner. Search order is `last+1`, `last+2`, … wrapping modulo N, ending at `last`.
- IDLE → GRANT: any `req` bit is sampled high. The winner is the first set bit in search order. On the same edge:
  - `gnt[winner]` is set to 1.
  - `gnt_id` is set to winner.
  - `last` is set to winner.
- GRANT → GRANT: `req[gnt_id]` is sampled high. The grant is unchanged. Other requests are ignored and stay pending without being lost.
- GRANT → IDLE: `req[gnt_id]` is sampled low. `gnt` clears on that edge. No new grant is issued on the same edge, so there is always at least one idle cycle between owners (bus turnaround).
- If only one requester is active, it may re-acquire after its one idle cycle. Round-robin only reorders competing requests.
- Changes to `req` bits other than the owner's have no effect while in GRANT.
- Reset values:
  - state = IDLE.
  - `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0, `any_req` = 0, `timeout` = 0.
  - `last` = N-1, so requester 0 has first priority after reset.
- Reset asserted mid-grant: on the next edge all outputs take their reset values regardless of `req`. The pointer also resets.
- `any_req` is informational only, for power gating or clock-enable of the resource. It does not affect arbitration.

## Timing
- Request to grant latency: `req` rises before edge k, so `gnt` is high after edge k. That is 1 cycle when idle.
- Release to grant-drop: owner's `req` falls before edge k, so `gnt` is low after edge k.
- Handover: owner A drops before edge k, and B has been waiting. `gnt` is 0 after edge k and `gnt[B]` is 1 after edge k+1. Minimum gap is 1 cycle.
- All outputs come directly from flops; there is no combinational path from `req` to any output.
- Worst-case wait for requester i, with every owner releasing within H cycles: (N-1)×(H+1)+1 cycles.

## Configuration
- `SEH_RR_ARB_TIMEOUT_EN` defined:
  - A hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - When the counter equals TIMEOUT-1 and `req[gnt_id]` is still high, the next edge clears `gnt`, enters IDLE, and pulses `timeout` high for exactly one cycle.
  - The evicted requester re-competes normally. Because `last` equals its index, it gets lowest priority.
  - If the owner releases on the same edge the timeout would fire, the transition is a normal release and `timeout` stays 0.
- `SEH_RR_ARB_TIMEOUT_EN` undefined:
  - There is no counter logic.
  - `timeout` is tied to 0.
  - Grants are held indefinitely.

## Test plan
- Reset then single request: `req`=0001 held 5 cycles, then dropped. Expect `gnt`=0001 and `gnt_id`=0 one cycle after `req` rises, and `gnt`=0 one cycle after `req` drops; `any_req` tracks `req` with a 1-cycle delay.
- Simultaneous requests after reset: `req`=1111, each owner holds 3 cycles after its grant and then drops. Expect grant order 0,1,2,3, each followed by one idle cycle, with `gnt_valid` low in each gap.
- Fairness wrap: the last owner was 2, then `req`=0101 with both held. Expect requester 0 to win (search order 3,0,1,2). After 0 releases, requester 2 wins.
- Reset mid-grant: `gnt`=0100 active, pulse `resetn` low for 1 cycle with `req`=0100 held. Expect all outputs 0 after that edge, then `gnt`=0100 again on the first edge after reset is released.
- Timeout (macro on, TIMEOUT=4): `req`=0011 held constantly. Expect `gnt`=0001 for 4 cycles, a `timeout` pulse, 1 idle cycle, then `gnt`=0010 for 4 cycles, and so on alternating.
- Timeout boundary (macro on, TIMEOUT=4): the owner drops `req` on the same edge the 4th cycle completes. Expect `gnt`=0 and `timeout` to stay 0.

Source files
------------

// File: rtl/seh_rr_arbiter.sv
// Round-robin arbiter: one-hot registered grant, held until the owner drops its request.
// Optional forced release after TIMEOUT cycles when SEH_RR_ARB_TIMEOUT_EN is defined.
module seh_rr_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 any_req,
  output logic                 timeout
);

  localparam int IDW = $clog2(N);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("seh_rr_arbiter: N out of range 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("seh_rr_arbiter: TIMEOUT out of range 1..65535");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_gnt, w_gnt_nxt;
  logic [IDW-1:0] r_id, w_id_nxt;
  logic [IDW-1:0] r_last, w_last_nxt;
  logic [IDW-1:0] w_winner;
  logic           w_found;
  logic           w_own_req;
  logic           w_fire;
  logic           r_valid;
  logic           r_any;
  int             w_idx;

  // Walk the search order backwards so the earliest candidate after r_last wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_found  = 1'b0;
    w_winner = r_last;
    w_idx    = 0;
    for (int k = N; k >= 1; k--) begin
      w_idx = (int'(r_last) + k) % N;
      if (req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = IDW'(w_idx);
      end
    end
  end

  assign w_own_req = req[r_id];

`ifdef SEH_RR_ARB_TIMEOUT_EN
  logic [15:0] r_hold;
  logic        r_timeout;

  assign w_fire = (r_hold == 16'(TIMEOUT - 1));

  // Counter sits at zero while idle, so it is already cleared on entry to GRANT.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_hold    <= (w_state_nxt == S_GRANT && r_state == S_GRANT) ? r_hold + 16'd1 : '0;
      r_timeout <= (r_state == S_GRANT) && w_own_req && w_fire;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_fire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_id_nxt    = r_id;
    w_last_nxt  = r_last;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt          = S_GRANT;
          w_gnt_nxt            = '0;
          w_gnt_nxt[w_winner]  = 1'b1;
          w_id_nxt             = w_winner;
          w_last_nxt           = w_winner;
        end
      end
      S_GRANT: begin
        // A release always wins over a coincident timeout.
        if (!w_own_req || w_fire) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!resetn) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_id    <= '0;
      r_last  <= IDW'(N - 1);
      r_valid <= 1'b0;
      r_any   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_id    <= w_id_nxt;
      r_last  <= w_last_nxt;
      r_valid <= (w_state_nxt == S_GRANT);
      r_any   <= |req;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_valid;
  assign gnt_id    = r_id;
  assign any_req   = r_any;

endmodule

// File: tb/tb_seh_rr_arbiter.sv
// Self-checking bench for seh_rr_arbiter: directed scenarios then randomized requests,
// compared each cycle against a behavioural round-robin model.
module tb_seh_rr_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 4;
`ifdef SEH_RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic         any_req;
  logic         timeout;

  seh_rr_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .any_req   (any_req),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int step_no = 0;

  // Model state: owner is -1 when nobody holds the resource.
  int m_owner, m_last, m_id, m_hold;
  bit m_any, m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
  endtask

  task automatic model_update(input logic [N-1:0] r, input logic rn);
    bit found;
    int c;
    if (!rn) begin
      m_owner = -1; m_last = N - 1; m_id = 0; m_any = 0; m_to = 0; m_hold = 0;
      return;
    end
    m_any = |r;
    m_to  = 0;
    if (m_owner < 0) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && r[c]) begin
          found = 1; m_owner = c; m_last = c; m_id = c; m_hold = 0;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (TO_EN && m_hold == TIMEOUT - 1) begin
      m_owner = -1;
      m_to    = 1;
    end else begin
      m_hold++;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check("gnt",       32'(gnt),       32'(eg));
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("gnt_id",    32'(gnt_id),    32'(m_id));
    check("any_req",   32'(any_req),   32'(m_any));
    check("timeout",   32'(timeout),   32'(m_to));
  endtask

  // Drive at the falling edge, clock once, then compare on the next falling edge.
  task automatic step(input logic [N-1:0] r, input logic rn = 1'b1);
    req    = r;
    resetn = rn;
    @(posedge clk);
    model_update(r, rn);
    @(negedge clk);
    step_no++;
    compare_all();
  endtask

  initial begin
    logic [N-1:0] mask;
    logic [N-1:0] rr;
    int           held;
    int           order[$];
    bit           prev_valid;

    req    = '0;
    resetn = 1'b0;
    @(negedge clk);

    // Reset state.
    step('0, 1'b0);
    step('0, 1'b0);

    // Single requester: grant after one edge, drop after one edge.
    repeat (5) step(4'b0001);
    check("single_gnt_while_held", 32'(gnt), 32'h1);
    step(4'b0000);
    check("single_gnt_dropped", 32'(gnt), 32'h0);
    step(4'b0000);

    // All four request after reset; each owner holds 3 cycles.
    step('0, 1'b0);
    mask = 4'b1111; held = 0; prev_valid = 1'b0;
    for (int i = 0; i < 40 && (mask != 0 || gnt_valid); i++) begin
      step(mask);
      if (gnt_valid && !prev_valid) order.push_back(int'(gnt_id));
      prev_valid = gnt_valid;
      if (m_owner >= 0) begin
        held++;
        if (held == 3) begin mask[m_owner] = 1'b0; held = 0; end
      end
    end
    check("rr_all_done", 32'(mask), 32'h0);
    check("rr_order_len", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size() && i < 4; i++) check("rr_order", 32'(order[i]), 32'(i));

    // Fairness wrap: last owner 2, then 0 and 2 compete.
    step(4'b0100);
    step(4'b0000);
    step(4'b0101);
    check("wrap_first_owner", 32'(gnt), 32'h1);
    step(4'b0101);
    step(4'b0100);
    step(4'b0100);
    check("wrap_second_owner", 32'(gnt), 32'h4);

    // Reset mid-grant with the request still held.
    step(4'b0100, 1'b0);
    check("midreset_gnt", 32'(gnt), 32'h0);
    step(4'b0100);
    check("after_reset_gnt", 32'(gnt), 32'h4);
    step(4'b0000);
    step(4'b0000);

    // Two requesters held constantly: alternates on timeout when enabled.
    repeat (16) step(4'b0011);
    step(4'b0000);
    step(4'b0000);

    // Owner drops exactly as the 4th hold cycle completes: normal release.
    step(4'b0001);
    repeat (3) step(4'b0001);
    step(4'b0000);
    check("boundary_timeout", 32'(timeout), 32'h0);
    check("boundary_gnt", 32'(gnt), 32'h0);

    // Randomized slowly-changing requests with occasional resets.
    rr = '0;
    for (int i = 0; i < 400; i++) begin
      rr = rr ^ N'($urandom & $urandom);
      step(rr, ($urandom_range(63) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
